// File: rtl/golay_enc_arb.sv
// Round-robin arbiter feeding one shared extended Golay (24,12) encoder with a registered codeword stage.
// Optional grant locking is compiled in with GOLAY_ENC_ARB_LOCK_EN.

package golay_pkg;
   // Row k = {parity bits 23..12, identity bit k in 11..0}
   localparam logic [23:0] golay_matrix [12] = '{
      24'hDC5001, 24'hB8B002, 24'h717004, 24'hE2D008,
      24'hC5B010, 24'h8B7020, 24'h16F040, 24'h2DD080,
      24'h5B9100, 24'hB71200, 24'h6E3400, 24'hFFE800
   };
endpackage

module golay_enc_arb #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_vld,
   input  logic [N*12-1:0] req_dat,
   output logic [N-1:0]    req_rdy,
   input  logic [N-1:0]    req_lck,
   output logic            out_vld,
   output logic [23:0]     out_cod,
   output logic [IW-1:0]   out_sel,
   input  logic            out_rdy
);

   // Handshake: a word moves from requester i when req_vld[i] & req_rdy[i] at a rising edge;
   // the codeword moves downstream when out_vld & out_rdy at a rising edge.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] win;
   logic [IW-1:0] nxt_ptr;
   logic [N-1:0]  eff_vld;
   logic          found;
   logic          ld;
   logic          xfer;
   logic          ptr_adv;
   logic [11:0]   win_dat;
   logic [23:0]   enc_cod;

`ifdef GOLAY_ENC_ARB_LOCK_EN
   logic          lck_on;
   logic [IW-1:0] lck_own;

   // While locked, everyone but the owner is masked out, even when the owner is idle.
   always_comb begin
      eff_vld = req_vld;
      if (lck_on) eff_vld = req_vld & (N'(1) << lck_own);
   end

   // Lock state follows the owner's req_lck on each of its transfers, so a single
   // bit covers both setting and releasing; the pointer only moves on an unlocked transfer.
   assign ptr_adv = !req_lck[win];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lck_on  <= 1'b0;
         lck_own <= '0;
      end else if (xfer) begin
         lck_on  <= req_lck[win];
         lck_own <= win;
      end
   end
`else
   logic unused_lck;

   assign eff_vld    = req_vld;
   assign ptr_adv    = 1'b1;
   assign unused_lck = ^req_lck;
`endif

   // First valid requester at or after rr_ptr, wrapping modulo N.
   always_comb begin
      int s;
      logic [IW-1:0] idx;
      found = 1'b0;
      win   = '0;
      s     = 0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         s = int'(rr_ptr) + k;
         if (s >= N) s = s - N;
         idx = IW'(s);
         if (!found && eff_vld[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign ld      = !out_vld || out_rdy;
   assign xfer    = found && ld && rst_n;
   assign req_rdy = xfer ? (N'(1) << win) : '0;
   assign nxt_ptr = (win == IW'(N - 1)) ? '0 : win + 1'b1;
   assign win_dat = req_dat[win*12 +: 12];

   always_comb begin
      enc_cod = '0;
      for (int k = 0; k < 12; k++) begin
         if (win_dat[k]) enc_cod = enc_cod ^ golay_pkg::golay_matrix[k];
      end
   end

   assign out_vld = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         out_cod <= '0;
         out_sel <= '0;
         rr_ptr  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (xfer) begin
                  state   <= FULL;
                  out_cod <= enc_cod;
                  out_sel <= win;
                  if (ptr_adv) rr_ptr <= nxt_ptr;
               end
            end
            FULL: begin
               if (xfer) begin
                  out_cod <= enc_cod;
                  out_sel <= win;
                  if (ptr_adv) rr_ptr <= nxt_ptr;
               end else if (out_rdy) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
